// File: rtl/nabp_sequencer_pkg.sv
// Shared types and sizing helpers for the NABP angle sequencer.
package nabp_sequencer_pkg;

    // Angle bus width used throughout the NABP datapath.
    localparam int kAngleLength = 10;
    localparam int ANGLE_WIDTH_DEFAULT = kAngleLength;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_FILL_KICK  = 4'd1,
        ST_FILL_WAIT  = 4'd2,
        ST_SHIFT_ARM  = 4'd3,
        ST_SHIFT_KICK = 4'd4,
        ST_SHIFT_WAIT = 4'd5,
        ST_NEXT       = 4'd6,
        ST_DONE       = 4'd7,
        ST_ERR        = 4'd8
    } seq_state_t;

    // Bits needed to index NUM_ANGLES angles; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bits needed for a watchdog that counts 0 .. t-1.
    function automatic int wd_width(input int t);
        return (t <= 2) ? 1 : $clog2(t);
    endfunction

endpackage

// File: rtl/nabp_wait_watchdog.sv
// Wait-state watchdog: counts cycles spent waiting and flags the last allowed cycle.
module nabp_wait_watchdog
    import nabp_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int WD_W = wd_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] LAST_COUNT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] count;

    // Expired marks the final allowed wait cycle; the FSM decides what to do with it.
    assign expired = (count == LAST_COUNT);

    // Count restarts on a kick and advances every waiting cycle, saturating at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + WD_W'(1);
        end
    end

endmodule

// File: rtl/nabp_angle_sequencer.sv
// Sweeps a projection angle range, driving one fill and one shift phase per angle.
//
// Shifter handshake: a kick is a one-cycle request pulse; the matching done is a
// level that the sequencer samples from the cycle after the kick onward. Shift
// kicks are only issued while pe_ready is high. No request is ever retracted.
module nabp_angle_sequencer
    import nabp_sequencer_pkg::*;
#(
    parameter int ANGLE_WIDTH    = ANGLE_WIDTH_DEFAULT,
    parameter int NUM_ANGLES     = 180,
    parameter int ANGLE_STEP     = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ANGLE_WIDTH-1:0] start_angle,
    input  logic                   abort,
    input  logic                   pe_ready,
    input  logic                   sc_fill_done,
    input  logic                   sc_shift_done,
    output logic [ANGLE_WIDTH-1:0] sc_angle,
    output logic                   sc_fill_kick,
    output logic                   sc_shift_kick,
    output logic                   busy,
    output logic                   sweep_done,
    output logic                   timeout_err,
    output seq_state_t             dbg_state
);

    localparam int IDX_W = idx_width(NUM_ANGLES);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_ANGLES - 1);
    localparam logic [ANGLE_WIDTH-1:0] STEP     = ANGLE_WIDTH'(ANGLE_STEP);

    seq_state_t       state;
    logic [IDX_W-1:0] angle_idx;
    logic             wd_clear;
    logic             wd_run;
    logic             wd_expired;

    // Watchdog restarts on each kick so it covers exactly the following wait state.
    assign wd_clear = (state == ST_FILL_KICK) || (state == ST_SHIFT_KICK);
    assign wd_run   = (state == ST_FILL_WAIT) || (state == ST_SHIFT_WAIT);

    nabp_wait_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .run    (wd_run),
        .expired(wd_expired)
    );

    // Moore outputs decoded straight from the state register.
    assign sc_fill_kick  = (state == ST_FILL_KICK);
    assign sc_shift_kick = (state == ST_SHIFT_KICK);
    assign sweep_done    = (state == ST_DONE);
    assign busy          = (state != ST_IDLE);
    assign dbg_state     = state;

    // Sequencer FSM with the angle and error registers it owns.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            sc_angle    <= '0;
            angle_idx   <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        sc_angle    <= start_angle;
                        angle_idx   <= '0;
                        timeout_err <= 1'b0;
                        state       <= ST_FILL_KICK;
                    end
                end
                ST_FILL_KICK: begin
                    state <= abort ? ST_IDLE : ST_FILL_WAIT;
                end
                ST_FILL_WAIT: begin
                    // Abort beats done, and done beats a coincident timeout.
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (sc_fill_done) begin
                        state <= ST_SHIFT_ARM;
                    end else if (wd_expired) begin
                        timeout_err <= 1'b1;
                        state       <= ST_ERR;
                    end
                end
                ST_SHIFT_ARM: begin
                    // Deliberately unbounded: downstream back-pressure is not an error.
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (pe_ready) begin
                        state <= ST_SHIFT_KICK;
                    end
                end
                ST_SHIFT_KICK: begin
                    state <= abort ? ST_IDLE : ST_SHIFT_WAIT;
                end
                ST_SHIFT_WAIT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (sc_shift_done) begin
                        state <= ST_NEXT;
                    end else if (wd_expired) begin
                        timeout_err <= 1'b1;
                        state       <= ST_ERR;
                    end
                end
                ST_NEXT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (angle_idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        angle_idx <= angle_idx + IDX_W'(1);
                        sc_angle  <= sc_angle + STEP;
                        state     <= ST_FILL_KICK;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_ERR: begin
                    timeout_err <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nabp_angle_sequencer.sv
// Self-checking bench for nabp_angle_sequencer (3 angles, step 1, 8-cycle watchdog).
module tb_nabp_angle_sequencer;
    import nabp_sequencer_pkg::*;

    localparam int AW = 10;
    localparam int NA = 3;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_angle = '0;
    logic          abort = 1'b0;
    logic          pe_ready = 1'b0;
    logic          sc_fill_done = 1'b0;
    logic          sc_shift_done = 1'b0;
    logic [AW-1:0] sc_angle;
    logic          sc_fill_kick;
    logic          sc_shift_kick;
    logic          busy;
    logic          sweep_done;
    logic          timeout_err;
    seq_state_t    dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_fill = 0;
    int n_shift = 0;
    int n_done = 0;
    int first_fill_cyc = -1;
    int done_cyc = -1;
    int t0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] mon_exp;

    nabp_angle_sequencer #(
        .ANGLE_WIDTH(AW),
        .NUM_ANGLES(NA),
        .ANGLE_STEP(1),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_angle  (start_angle),
        .abort        (abort),
        .pe_ready     (pe_ready),
        .sc_fill_done (sc_fill_done),
        .sc_shift_done(sc_shift_done),
        .sc_angle     (sc_angle),
        .sc_fill_kick (sc_fill_kick),
        .sc_shift_kick(sc_shift_kick),
        .busy         (busy),
        .sweep_done   (sweep_done),
        .timeout_err  (timeout_err),
        .dbg_state    (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    // Scoreboard: each fill kick must carry the next expected angle
    always @(negedge clk) begin
        if (!reset) begin
            if (sc_fill_kick) begin
                if (n_fill == 0) first_fill_cyc = cyc;
                n_fill++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL fill_kick_unexpected: kick with angle %0d, none expected", sc_angle);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (sc_angle !== mon_exp) begin
                        errors++;
                        $display("FAIL kick_angle: got %0d expected %0d", sc_angle, mon_exp);
                    end
                end
            end
            if (sc_shift_kick) n_shift++;
            if (sweep_done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_fill = 0;
        n_shift = 0;
        n_done = 0;
        first_fill_cyc = -1;
        done_cyc = -1;
    endtask

    task automatic do_start(input logic [AW-1:0] a);
        start_angle = a;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_wait: still busy after %0d cycles", name, budget);
        end
    endtask

    task automatic wait_state(input seq_state_t st, input int budget, input string name);
        int n;
        n = 0;
        while (dbg_state !== st && n < budget) begin
            step();
            n++;
        end
        if (dbg_state !== st) begin
            checks++;
            errors++;
            $display("FAIL %s_state_wait: state %0d, wanted %0d", name, dbg_state, st);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (sc_angle !== '0) begin errors++; $display("FAIL reset_angle: got %0d expected 0", sc_angle); end
        checks++; if ({sc_fill_kick, sc_shift_kick, busy, sweep_done, timeout_err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {sc_fill_kick, sc_shift_kick, busy, sweep_done, timeout_err});
        end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_sweep();
        sc_fill_done = 1'b1; sc_shift_done = 1'b1; pe_ready = 1'b1;
        clear_counts();
        exp_q.push_back(10'd10); exp_q.push_back(10'd11); exp_q.push_back(10'd12);
        do_start(10'd10);
        checks++; if (sc_fill_kick !== 1'b1) begin errors++; $display("FAIL basic_first_kick: got %b expected 1", sc_fill_kick); end
        // A start while busy must be ignored
        step(); step(); step();
        start_angle = 10'd500; start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(60, "basic");
        checks++; if (n_fill != 3 || n_shift != 3) begin errors++; $display("FAIL basic_kicks: fill=%0d shift=%0d expected 3/3", n_fill, n_shift); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", n_done); end
        checks++; if (done_cyc - first_fill_cyc != 6 * NA) begin errors++; $display("FAIL basic_done_latency: got %0d expected %0d", done_cyc - first_fill_cyc, 6 * NA); end
        checks++; if (cyc - done_cyc != 1) begin errors++; $display("FAIL basic_busy_drop: got %0d expected 1", cyc - done_cyc); end
        checks++; if (sc_angle !== 10'd12) begin errors++; $display("FAIL basic_angle_hold: got %0d expected 12", sc_angle); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_leftover: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_pe_stall();
        sc_fill_done = 1'b1; sc_shift_done = 1'b1; pe_ready = 1'b0;
        clear_counts();
        exp_q.push_back(10'd20); exp_q.push_back(10'd21); exp_q.push_back(10'd22);
        do_start(10'd20);
        wait_state(ST_SHIFT_ARM, 20, "stall");
        repeat (20) step();
        checks++; if (n_shift != 0) begin errors++; $display("FAIL stall_no_kick: got %0d expected 0", n_shift); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL stall_no_timeout: got %b expected 0", timeout_err); end
        checks++; if (dbg_state !== ST_SHIFT_ARM) begin errors++; $display("FAIL stall_state: got %0d expected %0d", dbg_state, ST_SHIFT_ARM); end
        pe_ready = 1'b1;
        step();
        checks++; if (sc_shift_kick !== 1'b1) begin errors++; $display("FAIL stall_release_kick: got %b expected 1", sc_shift_kick); end
        wait_idle(60, "stall");
        checks++; if (n_done != 1 || n_shift != 3) begin errors++; $display("FAIL stall_finish: done=%0d shift=%0d expected 1/3", n_done, n_shift); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_leftover: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int n;
        sc_fill_done = 1'b0; sc_shift_done = 1'b1; pe_ready = 1'b1;
        clear_counts();
        exp_q.push_back(10'd30);
        do_start(10'd30);
        step();
        checks++; if (dbg_state !== ST_FILL_WAIT) begin errors++; $display("FAIL timeout_enter: got %0d expected %0d", dbg_state, ST_FILL_WAIT); end
        t0 = cyc;
        n = 0;
        while (timeout_err !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++; if (cyc - t0 != TO) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", cyc - t0, TO); end
        step();
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_idle: busy=%b err=%b expected 0/1", busy, timeout_err); end
        checks++; if (n_done != 0) begin errors++; $display("FAIL timeout_no_done: got %0d expected 0", n_done); end
        // Next accepted start clears the sticky flag
        sc_fill_done = 1'b1;
        clear_counts();
        exp_q.push_back(10'd40); exp_q.push_back(10'd41); exp_q.push_back(10'd42);
        do_start(10'd40);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", timeout_err); end
        wait_idle(60, "timeout");
        checks++; if (n_done != 1 || exp_q.size() != 0) begin errors++; $display("FAIL timeout_rerun: done=%0d left=%0d expected 1/0", n_done, exp_q.size()); end
    endtask

    task automatic test_done_on_timeout();
        sc_fill_done = 1'b1; sc_shift_done = 1'b0; pe_ready = 1'b1;
        clear_counts();
        exp_q.push_back(10'd50); exp_q.push_back(10'd51); exp_q.push_back(10'd52);
        do_start(10'd50);
        wait_state(ST_SHIFT_WAIT, 20, "coincide");
        repeat (TO - 1) step();
        sc_shift_done = 1'b1;
        step();
        checks++; if (dbg_state !== ST_NEXT) begin errors++; $display("FAIL coincide_next: got %0d expected %0d", dbg_state, ST_NEXT); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL coincide_err: got %b expected 0", timeout_err); end
        wait_idle(60, "coincide");
        checks++; if (n_done != 1 || timeout_err !== 1'b0) begin errors++; $display("FAIL coincide_finish: done=%0d err=%b expected 1/0", n_done, timeout_err); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL coincide_leftover: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_abort();
        sc_fill_done = 1'b1; sc_shift_done = 1'b0; pe_ready = 1'b1;
        clear_counts();
        exp_q.push_back(10'd60);
        do_start(10'd60);
        wait_state(ST_SHIFT_WAIT, 20, "abort");
        abort = 1'b1; sc_shift_done = 1'b1;
        step();
        checks++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: state=%0d busy=%b expected %0d/0", dbg_state, busy, ST_IDLE); end
        checks++; if (n_done != 0 || timeout_err !== 1'b0) begin errors++; $display("FAIL abort_flags: done=%0d err=%b expected 0/0", n_done, timeout_err); end
        // Abort held in IDLE blocks a start
        start_angle = 10'd70; start = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || n_fill != 1) begin errors++; $display("FAIL abort_blocks_start: busy=%b fills=%0d expected 0/1", busy, n_fill); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_leftover: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_wrap_reset();
        int n;
        sc_fill_done = 1'b1; sc_shift_done = 1'b1; pe_ready = 1'b1;
        clear_counts();
        exp_q.push_back(10'd1023); exp_q.push_back(10'd0); exp_q.push_back(10'd1);
        do_start(10'd1023);
        wait_idle(60, "wrap");
        checks++; if (sc_angle !== 10'd1 || n_done != 1) begin errors++; $display("FAIL wrap_final: angle=%0d done=%0d expected 1/1", sc_angle, n_done); end
        clear_counts();
        exp_q.push_back(10'd1023); exp_q.push_back(10'd0);
        do_start(10'd1023);
        n = 0;
        while (n_fill < 2 && n < 30) begin
            step();
            n++;
        end
        step();
        reset = 1'b1;
        step();
        checks++; if (sc_angle !== '0 || {sc_fill_kick, sc_shift_kick, busy, sweep_done, timeout_err} !== 5'b0) begin
            errors++; $display("FAIL midreset_outputs: angle=%0d flags=%b expected 0/00000", sc_angle, {sc_fill_kick, sc_shift_kick, busy, sweep_done, timeout_err});
        end
        reset = 1'b0;
        step();
        step();
        checks++; if (busy !== 1'b0 || n_done != 0) begin errors++; $display("FAIL midreset_after: busy=%b done=%0d expected 0/0", busy, n_done); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midreset_leftover: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_pe_stall();
        test_timeout();
        test_done_on_timeout();
        test_abort();
        test_wrap_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
